mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and the
// data stage. Data wins by default; fetch is forced through after STARVE_MAX
// consecutive denied cycles. Reads return one cycle after the grant.
module mem_port_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [31:0]       if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic [31:0]       d_rdata,
  output logic              d_valid,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              stall_if
);

  typedef enum logic [1:0] {IDLE, DATA_RD, DATA_WR, FETCH} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state_reg, state_next;
  logic [3:0]  starve_reg, starve_next;
  logic [31:0] if_rdata_reg, d_rdata_reg;
  logic        if_gnt_c, d_gnt_c;

  // Grant decision; nothing is granted while reset is held low.
  always_comb begin
    if_gnt_c = 1'b0;
    d_gnt_c  = 1'b0;
    if (rst) begin
      if (if_req && (!d_req || starve_reg == STARVE_LIM)) begin
        if_gnt_c = 1'b1;
      end else if (d_req) begin
        d_gnt_c = 1'b1;
      end
    end
  end

  // Starvation counter: counts denied fetch cycles, saturating at the limit.
  always_comb begin
    starve_next = starve_reg;
    if (!if_req || if_gnt_c) begin
      starve_next = 4'd0;
    end else if (starve_reg < STARVE_LIM) begin
      starve_next = starve_reg + 4'd1;
    end
  end

  // Owner FSM next state and memory-side drive for the granted requester.
  always_comb begin
    state_next = IDLE;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_funct3 = 3'b000;
    mem_addr   = '0;
    mem_wdata  = 32'd0;
    if (d_gnt_c) begin
      state_next = d_we ? DATA_WR : DATA_RD;
      mem_read   = ~d_we;
      mem_write  = d_we;
      mem_funct3 = d_funct3;
      mem_addr   = d_addr;
      mem_wdata  = d_wdata;
    end else if (if_gnt_c) begin
      state_next = FETCH;
      mem_read   = 1'b1;
      mem_funct3 = 3'b010;
      mem_addr   = if_addr;
    end
  end

  // State register and starvation counter; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      starve_reg <= 4'd0;
    end else begin
      state_reg  <= state_next;
      starve_reg <= starve_next;
    end
  end

  // Capture read data on the edge after the grant; hold until the next capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata_reg <= 32'd0;
      d_rdata_reg  <= 32'd0;
    end else begin
      if (d_gnt_c && !d_we) begin
        d_rdata_reg <= mem_rdata;
      end
      if (if_gnt_c) begin
        if_rdata_reg <= mem_rdata;
      end
    end
  end

  assign if_gnt   = if_gnt_c;
  assign d_gnt    = d_gnt_c;
  assign if_rdata = if_rdata_reg;
  assign d_rdata  = d_rdata_reg;
  assign if_valid = (state_reg == FETCH);
  assign d_valid  = (state_reg == DATA_RD);
  assign stall_if = rst & if_req & ~if_gnt_c;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset behaviour, fetch, store, load,
// starvation rotation, back-to-back accesses and reset mid-access.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic [31:0]       if_rdata;
  logic              if_valid;
  logic              d_req;
  logic              d_we;
  logic [2:0]        d_funct3;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic [31:0]       d_rdata;
  logic              d_valid;
  logic              mem_read;
  logic              mem_write;
  logic [2:0]        mem_funct3;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              stall_if;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_if(stall_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected grant pattern: 1 = fetch, 0 = data.
  logic [7:0] pat_a;
  logic [6:0] pat_b;
  logic [6:0] both_b;

  initial begin
    rst = 1'b0; if_req = 1'b1; if_addr = 6'd1; d_req = 1'b1; d_we = 1'b0;
    d_funct3 = 3'b001; d_addr = 6'd2; d_wdata = 32'h1; mem_rdata = 32'hDEADBEEF;
    step();
    #1;
    // Reset: all outputs quiet even with requests pending
    chk("rst_if_gnt",   32'(if_gnt),    32'd0);
    chk("rst_d_gnt",    32'(d_gnt),     32'd0);
    chk("rst_mem_read", 32'(mem_read),  32'd0);
    chk("rst_mem_wr",   32'(mem_write), 32'd0);
    chk("rst_stall",    32'(stall_if),  32'd0);
    chk("rst_if_valid", 32'(if_valid),  32'd0);
    chk("rst_d_valid",  32'(d_valid),   32'd0);
    chk("rst_if_rdata", if_rdata,       32'd0);
    chk("rst_d_rdata",  d_rdata,        32'd0);

    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();

    // Idle for 5 cycles
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("idle_rd_%0d", i),   32'(mem_read),  32'd0);
      chk($sformatf("idle_wr_%0d", i),   32'(mem_write), 32'd0);
      chk($sformatf("idle_addr_%0d", i), 32'(mem_addr),  32'd0);
      chk($sformatf("idle_dv_%0d", i),   32'(d_valid),   32'd0);
      chk($sformatf("idle_iv_%0d", i),   32'(if_valid),  32'd0);
      step();
    end

    // Single fetch
    if_req = 1'b1; if_addr = 6'd4; mem_rdata = 32'h11223344;
    #1;
    chk("f_if_gnt",   32'(if_gnt),     32'd1);
    chk("f_d_gnt",    32'(d_gnt),      32'd0);
    chk("f_mem_read", 32'(mem_read),   32'd1);
    chk("f_mem_addr", 32'(mem_addr),   32'd4);
    chk("f_funct3",   32'(mem_funct3), 32'd2);
    chk("f_stall",    32'(stall_if),   32'd0);
    step();
    if_req = 1'b0; mem_rdata = 32'h0;
    #1;
    chk("f_if_valid", 32'(if_valid), 32'd1);
    chk("f_if_rdata", if_rdata,      32'h11223344);
    chk("f_d_valid",  32'(d_valid),  32'd0);
    step();
    chk("f_if_valid_end", 32'(if_valid), 32'd0);
    chk("f_if_rdata_hold", if_rdata,     32'h11223344);

    // Single store
    d_req = 1'b1; d_we = 1'b1; d_addr = 6'd2; d_funct3 = 3'b000; d_wdata = 32'hAABBCCDD;
    #1;
    chk("s_d_gnt",     32'(d_gnt),      32'd1);
    chk("s_mem_write", 32'(mem_write),  32'd1);
    chk("s_mem_read",  32'(mem_read),   32'd0);
    chk("s_funct3",    32'(mem_funct3), 32'd0);
    chk("s_wdata",     mem_wdata,       32'hAABBCCDD);
    chk("s_addr",      32'(mem_addr),   32'd2);
    step();
    d_req = 1'b0; d_we = 1'b0;
    #1;
    chk("s_d_valid", 32'(d_valid), 32'd0);
    chk("s_d_rdata", d_rdata,      32'd0);

    // Both requesting for 8 cycles: D,D,D,F,D,D,D,F
    pat_a = 8'b1000_1000;
    if_req = 1'b1; if_addr = 6'd9; d_req = 1'b1; d_we = 1'b0; d_addr = 6'd7; d_funct3 = 3'b010;
    for (int i = 0; i < 8; i++) begin
      mem_rdata = 32'h100 + 32'(i);
      #1;
      chk($sformatf("rot_dg_%0d", i),   32'(d_gnt),    32'(!pat_a[i]));
      chk($sformatf("rot_ig_%0d", i),   32'(if_gnt),   32'(pat_a[i]));
      chk($sformatf("rot_st_%0d", i),   32'(stall_if), 32'(!pat_a[i]));
      chk($sformatf("rot_ad_%0d", i),   32'(mem_addr), pat_a[i] ? 32'd9 : 32'd7);
      if (i > 0) begin
        chk($sformatf("rot_dv_%0d", i), 32'(d_valid),  32'(!pat_a[i-1]));
        chk($sformatf("rot_iv_%0d", i), 32'(if_valid), 32'(pat_a[i-1]));
      end
      step();
    end
    if_req = 1'b0; d_req = 1'b0;
    #1;
    chk("rot_last_iv",  32'(if_valid), 32'd1);
    chk("rot_if_rdata", if_rdata,      32'h107);
    chk("rot_d_rdata",  d_rdata,       32'h106);

    // Dropping fetch clears the starvation count
    both_b = 7'b111_1011;   // cycle 2: data only
    pat_b  = 7'b100_0000;
    if_addr = 6'd10; d_addr = 6'd11;
    for (int i = 0; i < 7; i++) begin
      d_req = 1'b1; if_req = both_b[i];
      #1;
      chk($sformatf("clr_dg_%0d", i), 32'(d_gnt),  32'(!pat_b[i]));
      chk($sformatf("clr_ig_%0d", i), 32'(if_gnt), 32'(pat_b[i]));
      step();
    end
    if_req = 1'b0; d_req = 1'b0;
    step();

    // Load then fetch back to back
    d_req = 1'b1; d_we = 1'b0; d_addr = 6'd3; mem_rdata = 32'hA5A5A5A5;
    #1;
    chk("lf_d_gnt", 32'(d_gnt), 32'd1);
    chk("lf_read",  32'(mem_read), 32'd1);
    step();
    d_req = 1'b0; if_req = 1'b1; if_addr = 6'd5; mem_rdata = 32'h5A5A5A5A;
    #1;
    chk("lf_if_gnt",  32'(if_gnt),  32'd1);
    chk("lf_d_valid", 32'(d_valid), 32'd1);
    chk("lf_d_rdata", d_rdata,      32'hA5A5A5A5);
    chk("lf_iv_c2",   32'(if_valid), 32'd0);
    step();
    if_req = 1'b0; mem_rdata = 32'h0;
    #1;
    chk("lf_if_valid", 32'(if_valid), 32'd1);
    chk("lf_if_rdata", if_rdata,      32'h5A5A5A5A);
    chk("lf_dv_c3",    32'(d_valid),  32'd0);
    chk("lf_d_hold",   d_rdata,       32'hA5A5A5A5);
    step();

    // Reset asserted in the cycle after a load grant
    d_req = 1'b1; d_we = 1'b0; d_addr = 6'd6; mem_rdata = 32'h77777777;
    step();
    if_req = 1'b1;
    rst = 1'b0;
    #1;
    chk("ra_d_valid",  32'(d_valid),   32'd0);
    chk("ra_d_rdata",  d_rdata,        32'd0);
    chk("ra_if_rdata", if_rdata,       32'd0);
    chk("ra_d_gnt",    32'(d_gnt),     32'd0);
    chk("ra_if_gnt",   32'(if_gnt),    32'd0);
    chk("ra_read",     32'(mem_read),  32'd0);
    chk("ra_stall",    32'(stall_if),  32'd0);
    step();
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("ra_post_dv1", 32'(d_valid), 32'd0);
    step();
    chk("ra_post_dv2", 32'(d_valid), 32'd0);
    chk("ra_post_rd",  d_rdata,      32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
